// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/DM memory-port arbiter.
// The state encoding is fixed so that external checkers can decode the state register.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_I  = 3'd1,
        ST_BUSY_D  = 3'd2,
        ST_SC_FAIL = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int STREAK_W_DEF   = 3;

    // The memory is word addressed; the byte offset is carried by the byte enables.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ll_reservation.sv
// LL/SC reservation bit. An SC or a plain store completing kills the reservation;
// an LL completing sets it. Only one of these can complete in a given cycle.
module ll_reservation (
    input  logic clk,
    input  logic rst_n,
    input  logic ll_done,
    input  logic sc_done,
    input  logic st_done,
    output logic llbit
);

    logic llbit_q;
    logic llbit_d;

    always_comb begin
        llbit_d = llbit_q;
        if (sc_done || st_done) begin
            llbit_d = 1'b0;
        end else if (ll_done) begin
            llbit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end

    assign llbit = llbit_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access,
// returns read data to the owner and resolves SC success against the reservation bit.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int STREAK_W   = STREAK_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        dm_ll,
    input  logic        dm_sc,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_sc_ok,
    output logic        llbit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Handshakes: a requester raises *_req with a stable payload and holds both
    // until its one-cycle *_valid pulse; mem_req is held with a stable payload
    // until a one-cycle mem_ack, which carries mem_rdata in the same cycle.

    localparam logic [STREAK_W-1:0] STARVE_CAP = STREAK_W'(STARVE_MAX);

    arb_state_e          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [3:0]          mem_be_q,    mem_be_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic [31:0]         dm_rdata_q,  dm_rdata_d;
    logic                dm_valid_q,  dm_valid_d;
    logic                dm_sc_ok_q,  dm_sc_ok_d;
    logic                is_ll_q,     is_ll_d;
    logic                is_sc_q,     is_sc_d;

    logic fetch_wins;
    logic ll_done;
    logic sc_done;
    logic st_done;

    // Data normally wins; fetch only wins when data is idle or fetch is starving.
    assign fetch_wins = if_req && (!dm_req || (streak_q == STARVE_CAP));

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_valid_d  = 1'b0;
        dm_sc_ok_d  = 1'b0;
        is_ll_d     = is_ll_q;
        is_sc_d     = is_sc_q;
        ll_done     = 1'b0;
        sc_done     = 1'b0;
        st_done     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    streak_d = '0;
                end
                if (fetch_wins) begin
                    streak_d    = '0;
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = word_addr(if_addr);
                    mem_wdata_d = '0;
                    is_ll_d     = 1'b0;
                    is_sc_d     = 1'b0;
                end else if (dm_req) begin
                    if (if_req && (streak_q != STARVE_CAP)) begin
                        streak_d = streak_q + 1'b1;
                    end
                    is_ll_d = dm_ll;
                    is_sc_d = dm_sc;
                    // An SC without a reservation is answered locally, memory is untouched.
                    if (dm_sc && !llbit) begin
                        state_d = ST_SC_FAIL;
                    end else begin
                        state_d     = ST_BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dm_we;
                        mem_be_d    = dm_be;
                        mem_addr_d  = word_addr(dm_addr);
                        mem_wdata_d = dm_wdata;
                    end
                end
            end
            ST_BUSY_I: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    dm_rdata_d = mem_rdata;
                    dm_valid_d = 1'b1;
                    dm_sc_ok_d = is_sc_q;
                    ll_done    = is_ll_q && !mem_we_q;
                    sc_done    = is_sc_q;
                    st_done    = mem_we_q && !is_sc_q;
                    state_d    = ST_RESP;
                end
            end
            ST_SC_FAIL: begin
                dm_valid_d = 1'b1;
                dm_sc_ok_d = 1'b0;
                sc_done    = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= 32'h0;
            dm_valid_q  <= 1'b0;
            dm_sc_ok_q  <= 1'b0;
            is_ll_q     <= 1'b0;
            is_sc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_sc_ok_q  <= dm_sc_ok_d;
            is_ll_q     <= is_ll_d;
            is_sc_q     <= is_sc_d;
        end
    end

    ll_reservation u_ll_reservation (
        .clk     (clk),
        .rst_n   (rst_n),
        .ll_done (ll_done),
        .sc_done (sc_done),
        .st_done (st_done),
        .llbit   (llbit)
    );

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_sc_ok  = dm_sc_ok_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a variable-latency memory model,
// fetch/data requester tasks and a reference model of memory contents and the reservation.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'h0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_ll = 1'b0;
    logic        dm_sc = 1'b0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_sc_ok;
    logic        llbit;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_arr [int];
    logic [31:0] ref_mem [int];
    bit          ref_ll = 1'b0;

    bit   mem_auto   = 1'b1;
    bit   lat_rand   = 1'b0;
    int   mem_lat    = 2;
    logic manual_ack = 1'b0;

    int   req_rises = 0;
    int   iv_cnt    = 0;
    int   dv_cnt    = 0;
    logic req_prev  = 1'b0;
    iss_t issue_q[$];
    bit   grant_log[$];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ll     (dm_ll),
        .dm_sc     (dm_sc),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_sc_ok  (dm_sc_ok),
        .llbit     (llbit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] x;
        x = 32'(idx);
        return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int idx;
        idx = int'(addr[31:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic void ref_store(input logic [31:0] addr, input logic [3:0] be,
                                      input logic [31:0] wdata);
        logic [31:0] w;
        w = ref_word(addr);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        ref_mem[int'(addr[31:2])] = w;
    endfunction

    // Memory model: acks mem_req after a programmable number of cycles.
    initial begin : mem_model
        int cnt;
        int lat;
        int idx;
        logic [31:0] w;
        cnt = 0;
        lat = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (!mem_auto) begin
                cnt = 0;
                mem_ack = manual_ack;
            end else if (mem_req) begin
                if (cnt == 0) lat = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                if (cnt >= lat) begin
                    idx = int'(mem_addr[31:2]);
                    w = mem_arr.exists(idx) ? mem_arr[idx] : init_word(idx);
                    mem_rdata = w;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                        mem_arr[idx] = w;
                    end
                    mem_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        iss_t e;
        forever begin
            @(negedge clk);
            if (mem_req && !req_prev) req_rises++;
            req_prev = mem_req;
            if (mem_req && mem_ack) begin
                e.we = mem_we;
                e.be = mem_be;
                e.addr = mem_addr;
                e.wdata = mem_wdata;
                issue_q.push_back(e);
            end
            if (if_valid) begin
                iv_cnt++;
                grant_log.push_back(1'b0);
            end
            if (dm_valid) begin
                dv_cnt++;
                grant_log.push_back(1'b1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Called aligned just after a rising edge; returns aligned just after a rising edge.
    task automatic dm_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ll, input logic sc,
                         output logic [31:0] rd, output logic ok, output int cyc);
        dm_req = 1'b1;
        dm_we = we;
        dm_be = be;
        dm_addr = addr;
        dm_wdata = wdata;
        dm_ll = ll;
        dm_sc = sc;
        rd = 32'h0;
        ok = 1'b0;
        cyc = -1;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (dm_valid) begin
                cyc = c;
                rd = dm_rdata;
                ok = dm_sc_ok;
                break;
            end
        end
        n_checks++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL dm_timeout: no dm_valid for addr %h within %0d cycles", addr, TIMEOUT);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_ll = 1'b0;
        dm_sc = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] addr, output logic [31:0] rd,
                         output logic [2:0] st, output int cyc);
        if_req = 1'b1;
        if_addr = addr;
        rd = 32'h0;
        st = 3'h0;
        cyc = -1;
        for (int c = 0; c < TIMEOUT; c++) begin
            @(negedge clk);
            if (if_valid) begin
                cyc = c;
                rd = if_rdata;
                st = dut.streak_q;
                break;
            end
        end
        n_checks++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL if_timeout: no if_valid for addr %h within %0d cycles", addr, TIMEOUT);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        n_checks++;
        if ({mem_req, mem_we, mem_be, if_valid, dm_valid, dm_sc_ok, llbit} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0", {mem_req, mem_we, mem_be, if_valid, dm_valid, dm_sc_ok, llbit});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h exp 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        n_checks++;
        if (dut.streak_q !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_streak: got %0d exp 0", dut.streak_q);
        end
    endtask

    task automatic test_lone_fetch();
        logic [31:0] rd;
        logic [2:0]  st;
        int cyc, iv0, dv0;
        mem_lat = 2;
        mem_arr[32'h104 >> 2] = 32'h2408_0005;
        ref_mem[32'h104 >> 2] = 32'h2408_0005;
        issue_q.delete();
        iv0 = iv_cnt;
        dv0 = dv_cnt;
        if_op(32'h0000_0104, rd, st, cyc);
        @(posedge clk);
        #1;
        n_checks++;
        if (rd !== ref_word(32'h104)) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h exp %h", rd, ref_word(32'h104));
        end
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d exp 4", cyc);
        end
        n_checks++;
        if (issue_q.size() != 1 || issue_q[0].addr !== 32'h104 || issue_q[0].we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_mem_access: got %0d accesses, first %h exp one read of 00000104",
                     issue_q.size(), issue_q.size() > 0 ? issue_q[0] : '0);
        end
        n_checks++;
        if ((iv_cnt - iv0) != 1 || (dv_cnt - dv0) != 0) begin
            n_fail++;
            $display("FAIL fetch_pulses: got if %0d dm %0d exp if 1 dm 0", iv_cnt - iv0, dv_cnt - dv0);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] drd, frd;
        logic dok;
        logic [2:0] st;
        int dcyc, fcyc;
        mem_lat = 1;
        issue_q.delete();
        grant_log.delete();
        fork
            dm_op(1'b1, 4'b1100, 32'h0000_2002, 32'hAABB_CCDD, 1'b0, 1'b0, drd, dok, dcyc);
            if_op(32'h0000_0300, frd, st, fcyc);
        join
        ref_store(32'h2002, 4'b1100, 32'hAABB_CCDD);
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != 1'b1 || grant_log[1] != 1'b0) begin
            n_fail++;
            $display("FAIL simul_order: got %0d completions first %0d exp data then fetch",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 1'b0);
        end
        n_checks++;
        if (issue_q.size() != 2 || issue_q[0].addr !== 32'h2000 || issue_q[0].be !== 4'b1100 ||
            issue_q[0].we !== 1'b1 || issue_q[0].wdata !== 32'hAABB_CCDD) begin
            n_fail++;
            $display("FAIL simul_store: got %h exp we=1 be=c addr=00002000 wdata=aabbccdd",
                     issue_q.size() > 0 ? issue_q[0] : '0);
        end
        n_checks++;
        if (frd !== ref_word(32'h300) || ref_word(32'h2000) !== mem_arr[32'h2000 >> 2]) begin
            n_fail++;
            $display("FAIL simul_data: got fetch %h exp %h", frd, ref_word(32'h300));
        end
    endtask

    task automatic test_starvation();
        logic [2:0] st;
        logic [6:0] order;
        mem_lat = 0;
        grant_log.delete();
        fork
            begin : data_side
                logic [31:0] rd;
                logic ok;
                int cyc;
                for (int i = 0; i < 6; i++) begin
                    dm_op(1'b0, 4'hF, 32'h120 + 32'(i * 4), 32'h0, 1'b0, 1'b0, rd, ok, cyc);
                    n_checks++;
                    if (rd !== ref_word(32'h120 + 32'(i * 4))) begin
                        n_fail++;
                        $display("FAIL starve_load%0d: got %h exp %h", i, rd, ref_word(32'h120 + 32'(i * 4)));
                    end
                end
            end
            begin : fetch_side
                logic [31:0] rd;
                int cyc;
                if_op(32'h0000_1040, rd, st, cyc);
            end
        join
        order = 7'h0;
        for (int i = 0; i < 7; i++) begin
            if (i < grant_log.size()) order[6 - i] = grant_log[i];
        end
        n_checks++;
        if (grant_log.size() != 7 || order !== 7'b1111011) begin
            n_fail++;
            $display("FAIL starve_order: got %b (%0d grants) exp 1111011 (D=1, I=0)", order, grant_log.size());
        end
        n_checks++;
        if (st !== 3'd0) begin
            n_fail++;
            $display("FAIL starve_streak: got %0d exp 0 after fetch grant", st);
        end
    endtask

    task automatic test_llsc_ok();
        logic [31:0] rd;
        logic ok;
        int cyc, r0;
        mem_lat = 1;
        mem_arr[32'h100 >> 2] = 32'h7;
        ref_mem[32'h100 >> 2] = 32'h7;
        dm_op(1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 1'b0, rd, ok, cyc);
        ref_ll = 1'b1;
        n_checks++;
        if (rd !== 32'h7 || llbit !== 1'b1) begin
            n_fail++;
            $display("FAIL ll_load: got rdata %h llbit %b exp 00000007 1", rd, llbit);
        end
        r0 = req_rises;
        issue_q.delete();
        dm_op(1'b1, 4'hF, 32'h100, 32'h8, 1'b0, 1'b1, rd, ok, cyc);
        ref_store(32'h100, 4'hF, 32'h8);
        ref_ll = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || llbit !== 1'b0) begin
            n_fail++;
            $display("FAIL sc_ok: got sc_ok %b llbit %b exp 1 0", ok, llbit);
        end
        n_checks++;
        if ((req_rises - r0) != 1 || issue_q.size() != 1 || issue_q[0].we !== 1'b1 ||
            issue_q[0].wdata !== 32'h8 || mem_arr[32'h100 >> 2] !== ref_word(32'h100)) begin
            n_fail++;
            $display("FAIL sc_write: got %0d requests exp 1 write of 00000008", req_rises - r0);
        end
    endtask

    task automatic test_sc_fail();
        logic [31:0] rd;
        logic ok;
        int cyc, r0;
        mem_lat = 1;
        dm_op(1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 1'b0, rd, ok, cyc);
        dm_op(1'b1, 4'hF, 32'h200, 32'h1234_5678, 1'b0, 1'b0, rd, ok, cyc);
        ref_store(32'h200, 4'hF, 32'h1234_5678);
        ref_ll = 1'b0;
        n_checks++;
        if (llbit !== 1'b0) begin
            n_fail++;
            $display("FAIL store_kills_ll: got llbit %b exp 0", llbit);
        end
        r0 = req_rises;
        dm_op(1'b1, 4'hF, 32'h100, 32'h9, 1'b0, 1'b1, rd, ok, cyc);
        n_checks++;
        if (ok !== 1'b0 || cyc != 2) begin
            n_fail++;
            $display("FAIL sc_fail_resp: got sc_ok %b after %0d cycles exp 0 after 2", ok, cyc);
        end
        n_checks++;
        if ((req_rises - r0) != 0 || mem_arr[32'h100 >> 2] !== ref_word(32'h100)) begin
            n_fail++;
            $display("FAIL sc_fail_noreq: got %0d memory requests exp 0", req_rises - r0);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        logic ok;
        int cyc, dv0;
        mem_lat = 1;
        dm_op(1'b0, 4'hF, 32'h104, 32'h0, 1'b1, 1'b0, rd, ok, cyc);
        ref_ll = 1'b1;
        mem_auto = 1'b0;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_be = 4'hF;
        dm_addr = 32'h108;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || dut.state_q !== ST_BUSY_D || llbit !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_setup: got mem_req %b state %0d llbit %b exp 1 %0d 1",
                     mem_req, dut.state_q, llbit, ST_BUSY_D);
        end
        #2;
        rst_n = 1'b0;
        dm_req = 1'b0;
        ref_ll = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || llbit !== 1'b0 || dut.state_q !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midop_reset: got mem_req %b llbit %b state %0d exp 0 0 0", mem_req, llbit, dut.state_q);
        end
        dv0 = dv_cnt;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        manual_ack = 1'b1;
        @(posedge clk);
        #3;
        manual_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_auto = 1'b1;
        n_checks++;
        if ((dv_cnt - dv0) != 0 || mem_req !== 1'b0 || dut.state_q !== ST_IDLE || llbit !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_ack_ignored: got %0d dm_valid pulses mem_req %b state %0d exp 0 0 0",
                     dv_cnt - dv0, mem_req, dut.state_q);
        end
    endtask

    task automatic test_random();
        lat_rand = 1'b1;
        fork
            begin : fetch_side
                logic [31:0] rd;
                logic [31:0] a;
                logic [2:0]  st;
                int cyc;
                for (int i = 0; i < 12; i++) begin
                    a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
                    if_op(a, rd, st, cyc);
                    n_checks++;
                    if (rd !== ref_word(a)) begin
                        n_fail++;
                        $display("FAIL rnd_fetch%0d: addr %h got %h exp %h", i, a, rd, ref_word(a));
                    end
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin : data_side
                logic [31:0] rd, a, wd, exp_rd;
                logic [3:0]  be;
                logic ok, exp_ok;
                int cyc, op;
                for (int i = 0; i < 30; i++) begin
                    op = int'($urandom_range(0, 3));
                    a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                    wd = $urandom;
                    be = 4'($urandom_range(1, 15));
                    exp_rd = ref_word(a);
                    exp_ok = 1'b0;
                    case (op)
                        0: dm_op(1'b0, 4'hF, a, 32'h0, 1'b0, 1'b0, rd, ok, cyc);
                        1: dm_op(1'b1, be, a, wd, 1'b0, 1'b0, rd, ok, cyc);
                        2: dm_op(1'b0, 4'hF, a, 32'h0, 1'b1, 1'b0, rd, ok, cyc);
                        default: dm_op(1'b1, 4'hF, a, wd, 1'b0, 1'b1, rd, ok, cyc);
                    endcase
                    case (op)
                        1: begin
                            ref_store(a, be, wd);
                            ref_ll = 1'b0;
                        end
                        2: ref_ll = 1'b1;
                        3: begin
                            exp_ok = ref_ll;
                            if (ref_ll) ref_store(a, 4'hF, wd);
                            ref_ll = 1'b0;
                        end
                        default: ;
                    endcase
                    n_checks++;
                    if (((op == 0 || op == 2) && rd !== exp_rd) || ok !== exp_ok || llbit !== ref_ll) begin
                        n_fail++;
                        $display("FAIL rnd_data%0d: op %0d addr %h got rd %h ok %b ll %b exp rd %h ok %b ll %b",
                                 i, op, a, rd, ok, llbit, exp_rd, exp_ok, ref_ll);
                    end
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        lat_rand = 1'b0;
        n_checks++;
        for (int w = 32'h100 >> 2; w < (32'h120 >> 2); w++) begin
            if (ref_word(32'(w * 4)) !== (mem_arr.exists(w) ? mem_arr[w] : init_word(w))) begin
                n_fail++;
                $display("FAIL rnd_mem_image: word %0d got %h exp %h", w,
                         mem_arr.exists(w) ? mem_arr[w] : init_word(w), ref_word(32'(w * 4)));
                break;
            end
        end
    endtask

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_llsc_ok();
        test_sc_fail();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
